// File: rtl/pipe_pkg.sv
// Shared types and widths for the MEM/WB end of the pipeline.
package pipe_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Control half of the MEM/WB register; the data word is kept separately so DW can vary.
  typedef struct packed {
    logic             valid;
    logic             wr_en;
    logic [REG_W-1:0] rd;
  } wb_ctrl_t;

endpackage

// File: rtl/dmem_handshake_fsm.sv
// Data-memory req/ack sequencer: issues one access, waits for ack or timeout, drives stall.
module dmem_handshake_fsm
  import pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned DW      = DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          we_i,
  input  logic [DW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          dmem_ack_i,
  output logic          dmem_req_o,
  output logic          dmem_we_o,
  output logic [DW-1:0] dmem_addr_o,
  output logic [DW-1:0] dmem_wdata_o,
  output logic          busy_o,
  output logic          stall_c_o,
  output logic          done_c_o,
  output logic          timeout_c_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [DW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;

  // Next-state, request latching and the stall equation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    stall_c_o   = 1'b0;
    done_c_o    = 1'b0;
    timeout_c_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          stall_c_o = 1'b1;
          state_d   = ACCESS;
          req_d     = 1'b1;
          we_d      = we_i;
          addr_d    = addr_i;
          wdata_d   = wdata_i;
          cnt_d     = '0;
        end
      end
      ACCESS: begin
        // An ack on the last allowed cycle still completes normally.
        if (dmem_ack_i) begin
          done_c_o = 1'b1;
          req_d    = 1'b0;
          state_d  = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_c_o = 1'b1;
          req_d       = 1'b0;
          state_d     = IDLE;
        end else begin
          stall_c_o = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign busy_o       = (state_q == ACCESS);

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB register: memory access sequencing, write-back port, error flags, retire count.
module mem_wb_stage
  import pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned DW      = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid34,
  input  logic [DW-1:0]    alu_result34,
  input  logic [DW-1:0]    store_data34,
  input  logic [REG_W-1:0] write_reg34,
  input  logic             wr_en34,
  input  logic             memtoreg34,
  input  logic             mem_read34,
  input  logic             memwrite34,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [DW-1:0]    dmem_addr,
  output logic [DW-1:0]    dmem_wdata,
  input  logic [DW-1:0]    dmem_rdata,
  input  logic             dmem_ack,
  output logic             stall,
  output logic             wr_en42,
  output logic [REG_W-1:0] write_reg42,
  output logic [DW-1:0]    write_data42,
  output logic             err_timeout,
  output logic             err_misalign,
  input  logic             err_clr,
  output logic [31:0]      retire_count
);

  logic memop_c;
  logic misalign_c;
  logic start_c;
  logic busy;
  logic fsm_stall_c;
  logic done_c;
  logic timeout_c;

  wb_ctrl_t      wb_q, wb_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic          err_to_q, err_to_d;
  logic          err_mis_q, err_mis_d;
  logic [31:0]   retire_q, retire_d;

  assign memop_c    = in_valid34 & (mem_read34 | memwrite34);
  assign misalign_c = |alu_result34[1:0];
  assign start_c    = ~busy & memop_c & ~misalign_c;

  dmem_handshake_fsm #(
    .TIMEOUT (TIMEOUT),
    .DW      (DW)
  ) u_fsm (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_c),
    .we_i         (memwrite34),
    .addr_i       (alu_result34),
    .wdata_i      (store_data34),
    .dmem_ack_i   (dmem_ack),
    .dmem_req_o   (dmem_req),
    .dmem_we_o    (dmem_we),
    .dmem_addr_o  (dmem_addr),
    .dmem_wdata_o (dmem_wdata),
    .busy_o       (busy),
    .stall_c_o    (fsm_stall_c),
    .done_c_o     (done_c),
    .timeout_c_o  (timeout_c)
  );

  // Stall is combinational from the inputs, so hold it low while reset is applied.
  assign stall = fsm_stall_c & ~rst;

  // MEM/WB next value; cycles spent waiting on memory load a bubble.
  always_comb begin
    wb_d      = '0;
    wb_data_d = wb_data_q;
    if (!busy) begin
      if (!start_c) begin
        wb_d.valid = in_valid34;
        wb_d.wr_en = wr_en34 & ~(memop_c & misalign_c);
        wb_d.rd    = write_reg34;
        wb_data_d  = alu_result34;
      end
    end else if (done_c) begin
      wb_d.valid = 1'b1;
      wb_d.wr_en = wr_en34;
      wb_d.rd    = write_reg34;
      wb_data_d  = memtoreg34 ? dmem_rdata : alu_result34;
    end else if (timeout_c) begin
      wb_d.valid = 1'b1;
      wb_d.wr_en = 1'b0;
      wb_d.rd    = write_reg34;
      wb_data_d  = alu_result34;
    end
  end

  // Sticky flags: clear first so a same-cycle new error wins.
  always_comb begin
    err_to_d  = err_clr ? 1'b0 : err_to_q;
    err_mis_d = err_clr ? 1'b0 : err_mis_q;
    if (timeout_c) err_to_d = 1'b1;
    if (!busy && memop_c && misalign_c) err_mis_d = 1'b1;
  end

  assign retire_d = retire_q + 32'(wb_d.valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q      <= '0;
      wb_data_q <= '0;
      err_to_q  <= 1'b0;
      err_mis_q <= 1'b0;
      retire_q  <= '0;
    end else begin
      wb_q      <= wb_d;
      wb_data_q <= wb_data_d;
      err_to_q  <= err_to_d;
      err_mis_q <= err_mis_d;
      retire_q  <= retire_d;
    end
  end

  assign wr_en42      = wb_q.valid & wb_q.wr_en & (wb_q.rd != '0);
  assign write_reg42  = wb_q.rd;
  assign write_data42 = wb_data_q;
  assign err_timeout  = err_to_q;
  assign err_misalign = err_mis_q;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage against a per-instruction transaction model.
module tb_mem_wb_stage;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid34;
  logic [31:0] alu_result34;
  logic [31:0] store_data34;
  logic [4:0]  write_reg34;
  logic        wr_en34;
  logic        memtoreg34;
  logic        mem_read34;
  logic        memwrite34;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        stall;
  logic        wr_en42;
  logic [4:0]  write_reg42;
  logic [31:0] write_data42;
  logic        err_timeout;
  logic        err_misalign;
  logic        err_clr;
  logic [31:0] retire_count;

  mem_wb_stage #(.TIMEOUT(TO), .DW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid34   (in_valid34),
    .alu_result34 (alu_result34),
    .store_data34 (store_data34),
    .write_reg34  (write_reg34),
    .wr_en34      (wr_en34),
    .memtoreg34   (memtoreg34),
    .mem_read34   (mem_read34),
    .memwrite34   (memwrite34),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .stall        (stall),
    .wr_en42      (wr_en42),
    .write_reg42  (write_reg42),
    .write_data42 (write_data42),
    .err_timeout  (err_timeout),
    .err_misalign (err_misalign),
    .err_clr      (err_clr),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned exp_retire = 0;
  bit          exp_emis = 1'b0;
  bit          exp_eto  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bubble();
    in_valid34   = 1'b0;
    alu_result34 = '0;
    store_data34 = '0;
    write_reg34  = '0;
    wr_en34      = 1'b0;
    memtoreg34   = 1'b0;
    mem_read34   = 1'b0;
    memwrite34   = 1'b0;
    dmem_ack     = 1'b0;
    dmem_rdata   = '0;
    err_clr      = 1'b0;
  endtask

  // One instruction end to end; ack_cycle = k acks in the k-th waiting cycle, 0 or >TO never acks.
  task automatic do_op(input bit v, input bit rd_op, input bit wr_op, input bit m2r, input bit wen,
                       input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [31:0] rdata, input int ack_cycle, input bit clr, input bit spur);
    bit          memop, mis, exp_wen;
    int          exp_stalls, stalls, c;
    logic [31:0] exp_data;
    logic        s;

    memop = v && (rd_op || wr_op);
    mis   = (addr[1:0] != 2'b00);
    if (clr) begin
      exp_emis = 1'b0;
      exp_eto  = 1'b0;
    end
    exp_data = addr;
    if (!memop || mis) begin
      exp_stalls = 0;
      exp_wen    = v && wen && !memop && (rd != 5'd0);
      if (memop) exp_emis = 1'b1;
    end else if (ack_cycle >= 1 && ack_cycle <= int'(TO)) begin
      exp_stalls = ack_cycle;
      exp_wen    = wen && (rd != 5'd0);
      if (m2r) exp_data = rdata;
    end else begin
      exp_stalls = int'(TO);
      exp_wen    = 1'b0;
      exp_eto    = 1'b1;
    end
    if (v) exp_retire++;

    in_valid34   = v;
    alu_result34 = addr;
    store_data34 = sdata;
    write_reg34  = rd;
    wr_en34      = wen;
    memtoreg34   = m2r;
    mem_read34   = rd_op;
    memwrite34   = wr_op;
    err_clr      = clr;
    dmem_ack     = 1'b0;
    #1;
    s = stall;
    stalls = 0;
    c = 0;
    while (s && c < int'(TO) + 3) begin
      stalls++;
      tick();
      c++;
      err_clr = 1'b0;
      check("req_held", 32'(dmem_req), 32'd1);
      if (c == 1) begin
        check("dmem_we", 32'(dmem_we), 32'(wr_op));
        check("dmem_addr", dmem_addr, addr);
        if (wr_op) check("dmem_wdata", dmem_wdata, sdata);
      end
      dmem_ack   = (c == ack_cycle);
      dmem_rdata = (c == ack_cycle) ? rdata : 32'($urandom);
      #1;
      s = stall;
    end
    check("stall_cycles", 32'(stalls), 32'(exp_stalls));
    tick();
    check("wr_en42", 32'(wr_en42), 32'(exp_wen));
    if (exp_wen) begin
      check("write_reg42", 32'(write_reg42), 32'(rd));
      check("write_data42", write_data42, exp_data);
    end
    check("req_done", 32'(dmem_req), 32'd0);
    check("retire", retire_count, exp_retire);
    check("err_misalign", 32'(err_misalign), 32'(exp_emis));
    check("err_timeout", 32'(err_timeout), 32'(exp_eto));

    drive_bubble();
    dmem_ack   = spur;
    dmem_rdata = 32'($urandom);
    tick();
    dmem_ack = 1'b0;
    check("bubble_wr_en42", 32'(wr_en42), 32'd0);
    check("bubble_req", 32'(dmem_req), 32'd0);
    check("bubble_retire", retire_count, exp_retire);
  endtask

  initial begin
    rst = 1'b1;
    drive_bubble();
    #12;
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_wr_en42", 32'(wr_en42), 32'd0);
    check("rst_retire", retire_count, 32'd0);
    check("rst_errs", {30'd0, err_timeout, err_misalign}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // R-type, load acked in 3rd wait cycle, store, timeout, clear, misaligned, $0 write, set-wins
    do_op(1, 0, 0, 0, 1, 5'd8, 32'h0000_1234, 32'h0, 32'h0, 0, 0, 0);
    do_op(1, 1, 0, 1, 1, 5'd9, 32'h40, 32'h0, 32'hDEAD_BEEF, 3, 0, 0);
    do_op(1, 0, 1, 0, 0, 5'd0, 32'h80, 32'hCAFE, 32'h0, 2, 0, 1);
    do_op(1, 1, 0, 1, 1, 5'd3, 32'h100, 32'h0, 32'h1111, 0, 0, 0);
    do_op(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 1, 0);
    do_op(1, 1, 0, 1, 1, 5'd4, 32'h41, 32'h0, 32'h0, 1, 0, 0);
    do_op(1, 0, 0, 0, 1, 5'd0, 32'h55, 32'h0, 32'h0, 0, 0, 0);
    do_op(1, 1, 1, 0, 1, 5'd7, 32'h200, 32'h77, 32'h99, int'(TO), 0, 0);
    do_op(1, 0, 1, 0, 0, 5'd1, 32'h202, 32'h5, 32'h0, 1, 1, 0);

    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = 32'($urandom);
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      do_op(($urandom_range(7) != 0), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            5'($urandom), a, 32'($urandom), 32'($urandom), int'($urandom_range(TO + 1)),
            ($urandom_range(7) == 0), 1'($urandom));
    end

    // Async reset in the middle of an outstanding access.
    in_valid34   = 1'b1;
    mem_read34   = 1'b1;
    memtoreg34   = 1'b1;
    wr_en34      = 1'b1;
    write_reg34  = 5'd5;
    alu_result34 = 32'h300;
    tick();
    tick();
    check("pre_rst_req", 32'(dmem_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_req", 32'(dmem_req), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_wr_en42", 32'(wr_en42), 32'd0);
    check("mid_rst_retire", retire_count, 32'd0);
    drive_bubble();
    exp_retire = 0;
    exp_emis   = 1'b0;
    exp_eto    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    do_op(1, 0, 0, 0, 1, 5'd12, 32'hABCD, 32'h0, 32'h0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access and write-back end of the five-stage pipeline; sits after the EX/MEM register.
- Issues loads/stores to a variable-latency data memory using a req/ack handshake, and stalls upstream while an access is outstanding.
- Holds the MEM/WB register and drives the register-bank write port (wr_en42, write_reg42, write_data42) that the ID stage consumes.

Parameters:
- TIMEOUT, 16: maximum cycles to wait for dmem_ack before aborting the access (legal range 2..255).
- DW, 32: data/address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid34  in  1  EX/MEM slot holds a real instruction (0 = bubble).
- alu_result34  in  DW  ALU result; this is the memory address for load/store.
- store_data34  in  DW  rt value to store.
- write_reg34  in  5  destination register.
- wr_en34  in  1  register write enable from the controller.
- memtoreg34  in  1  1 = write back load data; 0 = write back ALU result.
- mem_read34  in  1  load.
- memwrite34  in  1  store.
- dmem_req  out  1  access request; held until ack.
- dmem_we  out  1  1 = write.
- dmem_addr  out  DW  word address.
- dmem_wdata  out  DW  store data.
- dmem_rdata  in  DW  load data; valid when dmem_ack = 1.
- dmem_ack  in  1  single-cycle completion strobe.
- stall  out  1  freeze the PC, IF/ID, ID/EX and EX/MEM registers.
- wr_en42  out  1  register-bank write enable.
- write_reg42  out  5  register-bank write address.
- write_data42  out  DW  register-bank write data.
- err_timeout  out  1  sticky: an access timed out.
- err_misalign  out  1  sticky: a load/store address had addr[1:0] != 0.
- err_clr  in  1  synchronous clear of both sticky flags.
- retire_count  out  32  wrapping count of retired valid instructions.

Behaviour:
- Reset: asynchronous, active-high. Every output and register goes to 0, the state goes to IDLE, and any outstanding access is dropped; memory must ignore an ack that arrives after reset.
- Memory op: memop = in_valid34 & (mem_read34 | memwrite34).
- If mem_read34 and memwrite34 are both set, the store wins (dmem_we = 1) and the instruction is treated as a store.
- FSM states: IDLE, ACCESS.
- IDLE, no memop:
  - No stall.
  - On the next edge the MEM/WB register loads {in_valid34, wr_en34, write_reg34, alu_result34}.
  - Write-back is visible one cycle after the instruction is presented.
- IDLE, memop with alu_result34[1:0] != 0:
  - No request is issued, err_misalign is set, and there is no stall.
  - MEM/WB loads with its valid bit set but wr_en forced to 0. The instruction retires without writing.
- IDLE, aligned memop:
  - stall = 1 combinationally in that same cycle.
  - On the edge: dmem_req <= 1, dmem_we/addr/wdata are latched, the timeout counter is cleared, and the state goes to ACCESS.
- ACCESS, no ack:
  - stall = 1, dmem_req stays 1, and the counter increments.
  - When the counter reaches TIMEOUT-1, the next edge sets err_timeout, drops dmem_req, loads MEM/WB with wr_en = 0 (the instruction retires), and returns to IDLE. stall is 0 in that final cycle.
- ACCESS, dmem_ack = 1:
  - stall = 0 combinationally, so upstream advances on the same edge.
  - On that edge: dmem_req <= 0, MEM/WB loads with write data = memtoreg34 ? dmem_rdata : alu_result34, and the state returns to IDLE.
  - Load latency is (ack cycle − issue cycle) + 1.
- dmem_ack in IDLE is spurious and is ignored.
- The EX/MEM inputs are required to stay stable while stall = 1; the block does not re-sample them.
- Write-back outputs:
  - wr_en42 = wb_valid & wb_wr_en & (write_reg42 != 0). Writes to $0 are suppressed.
  - write_reg42 and write_data42 come straight from the MEM/WB register.
- retire_count increments by 1 on each edge where a valid instruction enters MEM/WB, and wraps from 0xFFFFFFFF to 0.
- Sticky error flags:
  - err_clr clears both flags.
  - If err_clr and a new error occur in the same cycle, the set wins.

Decomposition:
- Shared package (pipe_pkg): state encoding {IDLE, ACCESS}, DW, and the register-address width 5.
- One sub-module, dmem_handshake_fsm: owns the state register, timeout counter, dmem_req/we/addr/wdata registers and the stall equation.
- mem_wb_stage itself keeps the MEM/WB register, the write-back mux, the error flags and retire_count.

Test Plan:
- Reset: assert rst mid-ACCESS with dmem_req = 1 → dmem_req, stall, wr_en42 and retire_count are all 0 immediately, without waiting for a clock edge.
- R-type: alu_result34 = 0x0000_1234, write_reg34 = 8, wr_en34 = 1, no memop → next cycle wr_en42 = 1, write_reg42 = 8, write_data42 = 0x1234, stall never asserted.
- Load with 3-cycle ack: addr 0x40, write_reg34 = 9, memtoreg34 = 1, ack with rdata 0xDEADBEEF in the third ACCESS cycle → stall high for 3 cycles, then wr_en42 = 1, write_reg42 = 9, write_data42 = 0xDEADBEEF.
- Store: addr 0x80, store_data34 = 0xCAFE, wr_en34 = 0 → dmem_we = 1, dmem_wdata = 0xCAFE; after ack, wr_en42 = 0 and retire_count increments by 1.
- Timeout (TIMEOUT = 4), never ack → stall for 4 cycles, err_timeout = 1, wr_en42 = 0, FSM back in IDLE; err_clr then clears the flag.
- Misaligned load at addr 0x41 → no dmem_req, err_misalign = 1, no stall. Separately, write_reg34 = 0 with wr_en34 = 1 → wr_en42 stays 0.
